// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the HI/LO multiply/divide sequencer.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_t;

  localparam int unsigned MDU_MULT_LAT = 5;
  localparam int unsigned MDU_DIV_LAT  = 10;

  function automatic int unsigned cnt_width(input int unsigned mult_lat,
                                            input int unsigned div_lat);
    int unsigned mx;
    mx = (mult_lat > div_lat) ? mult_lat : div_lat;
    return (mx < 2) ? 1 : $clog2(mx);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational HI/LO result for the long-latency ops; wr=0 means HI/LO must not change.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        wr
);

  logic               div0;
  logic               ovf;
  logic [63:0]        sprod;
  logic [63:0]        uprod;
  logic signed [31:0] sdvs;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic [31:0]        udvs;

  assign div0  = (b == '0);
  assign ovf   = (a == 32'h8000_0000) && (b == '1);
  assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign uprod = {32'h0, a} * {32'h0, b};

  // Divisor forced to 1 on div0/overflow: avoids the trap cases, and a/1 with
  // remainder 0 is exactly the required overflow result (lo=0x8000_0000, hi=0).
  assign sdvs = (div0 || ovf) ? 32'sd1 : $signed(b);
  assign sq   = $signed(a) / sdvs;
  assign sr   = $signed(a) % sdvs;
  assign udvs = div0 ? 32'd1 : b;

  always_comb begin
    res = '0;
    wr  = 1'b0;
    case (op)
      MDU_MULT: begin
        res = sprod;
        wr  = 1'b1;
      end
      MDU_MULTU: begin
        res = uprod;
        wr  = 1'b1;
      end
      MDU_DIV: begin
        res = {sr, sq};
        wr  = !div0;
      end
      MDU_DIVU: begin
        res = {a % udvs, a / udvs};
        wr  = !div0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle mult/div sequencer: result computed at acceptance, held pending, committed after LAT cycles.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_LAT = MDU_MULT_LAT,
  parameter int unsigned DIV_LAT  = MDU_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned     CW        = cnt_width(MULT_LAT, DIV_LAT);
  localparam logic [CW-1:0]   MULT_LOAD = CW'(MULT_LAT - 1);
  localparam logic [CW-1:0]   DIV_LOAD  = CW'(DIV_LAT - 1);

  mdu_state_t    state;
  mdu_state_t    state_nx;
  logic [CW-1:0] cnt;
  logic [31:0]   p_hi;
  logic [31:0]   p_lo;
  logic          p_wr;
  logic [63:0]   calc_res;
  logic          calc_wr;
  logic          accept;
  logic          is_long;
  logic          is_div;
  logic          done;

  mdu_calc u_calc (
    .op  (op),
    .a   (a),
    .b   (b),
    .res (calc_res),
    .wr  (calc_wr)
  );

  always_comb begin
    accept  = start && !flush && (state == S_IDLE)
              && (op != MDU_NONE) && (op != MDU_RSVD);
    is_div  = (op == MDU_DIV) || (op == MDU_DIVU);
    is_long = (op == MDU_MULT) || (op == MDU_MULTU) || is_div;
    done    = (state == S_RUN) && (cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept && is_long) state_nx = S_RUN;
      S_RUN:  if (done)              state_nx = S_IDLE;
      default:                       state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      p_hi <= '0;
      p_lo <= '0;
      p_wr <= 1'b0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      if (accept && is_long) begin
        {p_hi, p_lo} <= calc_res;
        p_wr         <= calc_wr;
        cnt          <= is_div ? DIV_LOAD : MULT_LOAD;
      end else if (state == S_RUN && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (accept && op == MDU_MTHI) hi <= a;
      if (accept && op == MDU_MTLO) lo <= a;
      if (done && p_wr) begin
        hi <= p_hi;
        lo <= p_lo;
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI/LO queued at issue, compared when busy drops.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] m_hi, m_lo;
  logic [63:0] sb_q[$];

  mdu_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] mop, input logic [31:0] ma,
                                        input logic [31:0] mb, input logic [31:0] oh,
                                        input logic [31:0] ol);
    longint      sa, sb, q, r;
    logic [63:0] v, qv, rv;
    sa = longint'(signed'(ma));
    sb = longint'(signed'(mb));
    v  = {oh, ol};
    case (mop)
      3'd1: v = sa * sb;
      3'd2: v = {32'h0, ma} * {32'h0, mb};
      3'd3: if (mb != 0) begin
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        v  = {rv[31:0], qv[31:0]};
      end
      3'd4: if (mb != 0) v = {ma % mb, ma / mb};
      3'd5: v = {ma, ol};
      3'd6: v = {oh, ma};
      default: ;
    endcase
    return v;
  endfunction

  function automatic int unsigned lat_of(input logic [2:0] mop);
    if (mop == 3'd1 || mop == 3'd2) return 5;
    if (mop == 3'd3 || mop == 3'd4) return 10;
    return 0;
  endfunction

  // Entered and left at a negedge; the exit negedge is the first free cycle.
  // mid: 0 nothing, 1 mtlo start at busy cycle 2, 2 flush at busy cycle 2.
  task automatic run_op(input string tag, input logic [2:0] mop, input logic [31:0] ma,
                        input logic [31:0] mb, input int unsigned mid);
    logic [63:0] old, exp;
    int unsigned cnt;
    old = {m_hi, m_lo};
    exp = model(mop, ma, mb, m_hi, m_lo);
    sb_q.push_back(exp);
    {m_hi, m_lo} = exp;
    start = 1'b1; op = mop; a = ma; b = mb;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      if (cnt == 1) check({tag, "_old"}, {hi, lo}, old);
      if (cnt == 2 && mid == 1) begin
        start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF;
      end else if (cnt == 2 && mid == 2) begin
        flush = 1'b1;
      end else begin
        start = 1'b0; op = 3'd0; flush = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; op = 3'd0; flush = 1'b0;
    check({tag, "_lat"}, 64'(cnt), 64'(lat_of(mop)));
    if (sb_q.size() == 0) check({tag, "_sb_empty"}, 64'd1, 64'd0);
    else check({tag, "_res"}, {hi, lo}, sb_q.pop_front());
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_state", {63'(hi), busy}, {63'(0), 1'b0});
    check("reset_lo", 64'(lo), 64'd0);

    run_op("mult",  3'd1, 32'hFFFF_FFFE, 32'd3, 0);
    run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, 0);
    run_op("div",   3'd3, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu",  3'd4, 32'd7, 32'd2, 0);
    run_op("mthi",  3'd5, 32'h1234, 32'd0, 0);
    run_op("mtlo",  3'd6, 32'h5678, 32'd0, 0);
    run_op("divu0", 3'd4, 32'd99, 32'd0, 0);
    run_op("div0",  3'd3, 32'hFFFF_FF00, 32'd0, 0);

    // start under flush must be dropped
    start = 1'b1; op = 3'd1; a = 32'd6; b = 32'd7; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 3'd0; flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hilo", {hi, lo}, {m_hi, m_lo});
    @(negedge clk);
    check("flush_busy2", 64'(busy), 64'd0);

    run_op("mtlo_in_run", 3'd1, 32'h0001_0003, 32'h0002_0005, 1);
    run_op("flush_in_run", 3'd3, 32'd1000, 32'hFFFF_FFF9, 2);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    // reset during busy cycle 3 of a div
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd3;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    repeat (2) @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_after", {hi, lo}, 64'd0);
    check("rst_mid_busy0", 64'(busy), 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    check("rst_mid_stays_idle", {busy, hi, lo}, 65'd0);

    // back-to-back: each run_op starts in the first free cycle of the previous
    run_op("b2b_divu", 3'd4, 32'd100, 32'd7, 0);
    run_op("b2b_mult", 3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("b2b_mult2", 3'd1, 32'h1234_5678, 32'hFFFF_FFFF, 0);
    run_op("b2b_div", 3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
